// File: rtl/ksa_sched_ctrl.sv
// RC4 key-scheduling sequencer driving a single-port 256-byte S-box RAM.
// Optional S[i]=i initialisation pass is compiled in with KSA_INIT_PHASE_EN.
module ksa_sched_ctrl #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             mem_addr,
  output logic [7:0]             mem_wdata,
  output logic                   mem_wren,
  input  logic [7:0]             mem_q
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(KEY_BYTES - 1);

  typedef enum logic [3:0] {
    IDLE,
`ifdef KSA_INIT_PHASE_EN
    INIT,
`endif
    RD_I,
    LD_I,
    RD_J,
    LD_J,
    WR_I,
    WR_J,
    DONE
  } state_t;

  state_t                 state_reg, state_next;
  logic [7:0]             i_reg, i_next;
  logic [7:0]             j_reg, j_next;
  logic [KW-1:0]          k_reg, k_next;
  logic [7:0]             si_reg, si_next;
  logic [8*KEY_BYTES-1:0] key_reg, key_next;
  logic                   busy_reg, busy_next;
  logic                   done_reg, done_next;
  logic [7:0]             addr_reg, addr_next;
  logic [7:0]             wdata_reg, wdata_next;
  logic                   wren_reg, wren_next;

  // Key byte 0 sits in the most significant byte of the key word.
  logic [7:0] key_byte [KEY_BYTES];
  logic [7:0] kbyte;

  genvar gi;
  generate
    for (gi = 0; gi < KEY_BYTES; gi++) begin : g_key_byte
      assign key_byte[gi] = key_reg[8*(KEY_BYTES-1-gi) +: 8];
    end
  endgenerate

  assign kbyte = key_byte[k_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      i_reg     <= 8'd0;
      j_reg     <= 8'd0;
      k_reg     <= '0;
      si_reg    <= 8'd0;
      key_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      addr_reg  <= 8'd0;
      wdata_reg <= 8'd0;
      wren_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      i_reg     <= i_next;
      j_reg     <= j_next;
      k_reg     <= k_next;
      si_reg    <= si_next;
      key_reg   <= key_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      wren_reg  <= wren_next;
    end
  end

  // RAM controls are computed for the state being entered, so every output is a flop.
  always_comb begin
    state_next = state_reg;
    i_next     = i_reg;
    j_next     = j_reg;
    k_next     = k_reg;
    si_next    = si_reg;
    key_next   = key_reg;
    busy_next  = busy_reg;
    done_next  = done_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    wren_next  = 1'b0;

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          key_next  = key;
          i_next    = 8'd0;
          j_next    = 8'd0;
          k_next    = '0;
          done_next = 1'b0;
          busy_next = 1'b1;
          addr_next = 8'd0;
`ifdef KSA_INIT_PHASE_EN
          state_next = INIT;
          wdata_next = 8'd0;
          wren_next  = 1'b1;
`else
          state_next = RD_I;
`endif
        end
      end

`ifdef KSA_INIT_PHASE_EN
      INIT: begin
        if (i_reg == 8'd255) begin
          i_next     = 8'd0;
          addr_next  = 8'd0;
          state_next = RD_I;
        end else begin
          i_next     = i_reg + 8'd1;
          addr_next  = i_reg + 8'd1;
          wdata_next = i_reg + 8'd1;
          wren_next  = 1'b1;
        end
      end
`endif

      RD_I: state_next = LD_I;

      LD_I: begin
        si_next    = mem_q;
        j_next     = j_reg + mem_q + kbyte;
        addr_next  = j_reg + mem_q + kbyte;
        state_next = RD_J;
      end

      RD_J: state_next = LD_J;

      // The write-data flop doubles as the S[j] holding register.
      LD_J: begin
        wdata_next = mem_q;
        addr_next  = i_reg;
        wren_next  = 1'b1;
        state_next = WR_I;
      end

      WR_I: begin
        addr_next  = j_reg;
        wdata_next = si_reg;
        wren_next  = 1'b1;
        state_next = WR_J;
      end

      WR_J: begin
        if (i_reg == 8'd255) begin
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = DONE;
        end else begin
          i_next     = i_reg + 8'd1;
          k_next     = (k_reg == K_LAST) ? '0 : k_reg + 1'b1;
          addr_next  = i_reg + 8'd1;
          state_next = RD_I;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign mem_wren  = wren_reg;

endmodule

// File: tb/tb_ksa_sched_ctrl.sv
// Bench for ksa_sched_ctrl: behavioural RAM plus a software RC4 KSA reference.
module tb_ksa_sched_ctrl;

`ifdef KSA_INIT_PHASE_EN
  localparam int DONE_CYC = 1793;
  localparam int BUSY_CYC = 1792;
  localparam int WR_CNT   = 768;
  localparam int FIRST_WR = 1;
  localparam int RST_CYC  = 903;
`else
  localparam int DONE_CYC = 1537;
  localparam int BUSY_CYC = 1536;
  localparam int WR_CNT   = 512;
  localparam int FIRST_WR = 5;
  localparam int RST_CYC  = 900;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [23:0] key = 24'd0;
  logic        busy, done, mem_wren;
  logic [7:0]  mem_addr, mem_wdata, mem_q;

  logic [7:0]  ram  [256];
  logic [7:0]  snap [256];
  logic [7:0]  gold [256];
  logic        preload_id = 1'b0;
  logic        preload_rand = 1'b0;

  int checks = 0;
  int errors = 0;

  int r_busy_cnt, r_done_cyc, r_init_bad, r_wr_cnt, r_first_wr, r_done_c1;
  logic r_pre_busy, r_pre_wren, r_post_busy, r_post_wren, r_post_done;
  logic [7:0] r_post_addr;

  ksa_sched_ctrl #(.KEY_BYTES(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wren(mem_wren), .mem_q(mem_q)
  );

  always #10 clk = ~clk;

  // Single-port RAM with registered read; contents survive DUT reset.
  always @(posedge clk) begin
    if (preload_id) begin
      for (int a = 0; a < 256; a++) ram[a] <= 8'(a);
    end else if (preload_rand) begin
      for (int a = 0; a < 256; a++) ram[a] <= 8'($urandom);
    end else if (mem_wren) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_q <= ram[mem_addr];
  end

  task automatic do_preload();
    @(negedge clk);
`ifdef KSA_INIT_PHASE_EN
    preload_rand = 1'b1;
`else
    preload_id = 1'b1;
`endif
    @(negedge clk);
    preload_rand = 1'b0;
    preload_id   = 1'b0;
  endtask

  // Reference RC4 key schedule applied to the starting contents in snap.
  task automatic compute_gold(input logic [23:0] k);
    logic [7:0] s [256];
    logic [7:0] t;
    int j;
    for (int a = 0; a < 256; a++) s[a] = snap[a];
    j = 0;
    for (int i = 0; i < 256; i++) begin
      j = (j + int'(s[i]) + int'(k[8*(2 - (i % 3)) +: 8])) % 256;
      t = s[i];
      s[i] = s[j];
      s[j] = t;
    end
    for (int a = 0; a < 256; a++) gold[a] = s[a];
  endtask

  function automatic int ram_diff();
    for (int a = 0; a < 256; a++)
      if (ram[a] !== gold[a]) return a;
    return -1;
  endfunction

  // Starts one run and records observations; rst_at > 0 aborts it with a reset.
  task automatic run_ksa(input logic [23:0] k, input int inj_at, input int rst_at);
    r_busy_cnt = 0; r_done_cyc = -1; r_init_bad = 0; r_wr_cnt = 0;
    r_first_wr = -1; r_done_c1 = -1;
    for (int a = 0; a < 256; a++) begin
`ifdef KSA_INIT_PHASE_EN
      snap[a] = 8'(a);
`else
      snap[a] = ram[a];
`endif
    end
    compute_gold(k);
    @(negedge clk);
    key = k;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 2000; c++) begin
      if (c > 1) @(negedge clk);
      if (c == rst_at) begin
        r_pre_busy = busy;
        r_pre_wren = mem_wren;
        #2 rst_n = 1'b0;
        #1;
        r_post_busy = busy;
        r_post_wren = mem_wren;
        r_post_done = done;
        r_post_addr = mem_addr;
        break;
      end
      if (c == 1) r_done_c1 = int'(done);
      if (busy) r_busy_cnt++;
      if (mem_wren) begin
        r_wr_cnt++;
        if (r_first_wr < 0) r_first_wr = c;
      end
`ifdef KSA_INIT_PHASE_EN
      if (c <= 256 && !(mem_wren === 1'b1 && mem_addr === 8'(c - 1) && mem_wdata === 8'(c - 1)))
        r_init_bad++;
`endif
      if (c == inj_at) begin
        key = 24'hFFFFFF;
        start = 1'b1;
      end
      if (c == inj_at + 1) start = 1'b0;
      if (done === 1'b1) begin
        r_done_cyc = c;
        break;
      end
    end
  endtask

  task automatic check_run(input string name, input logic [23:0] k);
    int d;
    checks++;
    if (r_done_cyc !== DONE_CYC) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d expected %0d", name, r_done_cyc, DONE_CYC);
    end
    checks++;
    if (r_busy_cnt !== BUSY_CYC) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, r_busy_cnt, BUSY_CYC);
    end
    checks++;
    if (r_wr_cnt !== WR_CNT || r_first_wr !== FIRST_WR) begin
      errors++;
      $display("FAIL %s writes: got %0d first@%0d expected %0d first@%0d",
               name, r_wr_cnt, r_first_wr, WR_CNT, FIRST_WR);
    end
`ifdef KSA_INIT_PHASE_EN
    checks++;
    if (r_init_bad !== 0) begin
      errors++;
      $display("FAIL %s init_writes: got %0d bad cycles expected 0", name, r_init_bad);
    end
`endif
    d = ram_diff();
    checks++;
    if (d !== -1) begin
      errors++;
      $display("FAIL %s sbox: S[%0d] got %02h expected %02h", name, d, ram[d], gold[d]);
    end
    $display("run %s key=%06h done@%0d busy=%0d writes=%0d", name, k, r_done_cyc, r_busy_cnt, r_wr_cnt);
  endtask

  task automatic test_reset();
    #5 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (mem_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b expected 0", mem_wren); end
    checks++; if (mem_addr !== 8'd0) begin errors++; $display("FAIL reset_addr: got %02h expected 00", mem_addr); end
    checks++; if (mem_wdata !== 8'd0) begin errors++; $display("FAIL reset_wdata: got %02h expected 00", mem_wdata); end
    rst_n = 1'b1;
    $display("reset: busy=%b done=%b wren=%b addr=%02h", busy, done, mem_wren, mem_addr);
  endtask

  task automatic test_zero_key();
    do_preload();
    run_ksa(24'h000000, -1, -1);
    check_run("zero_key", 24'h000000);
  endtask

  task automatic test_key_249();
    do_preload();
    run_ksa(24'h000249, -1, -1);
    check_run("key_249", 24'h000249);
  endtask

  task automatic test_ignored_start();
    do_preload();
    run_ksa(24'h000249, 500, -1);
    check_run("ignored_start", 24'h000249);
  endtask

  task automatic test_reset_mid();
    do_preload();
    run_ksa(24'h000249, -1, RST_CYC);
    checks++;
    if (r_pre_busy !== 1'b1 || r_pre_wren !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: busy=%b wren=%b expected 1 1", r_pre_busy, r_pre_wren);
    end
    checks++;
    if (r_post_busy !== 1'b0 || r_post_wren !== 1'b0 || r_post_done !== 1'b0 || r_post_addr !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b wren=%b done=%b addr=%02h expected 0 0 0 00",
               r_post_busy, r_post_wren, r_post_done, r_post_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_wren !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_idle: busy=%b wren=%b done=%b expected 0 0 0", busy, mem_wren, done);
    end
    $display("reset at cycle %0d: busy=%b wren=%b", RST_CYC, r_post_busy, r_post_wren);
    do_preload();
    run_ksa(24'h000249, -1, -1);
    check_run("after_reset", 24'h000249);
  endtask

  task automatic test_random();
    logic [23:0] k;
    for (int n = 0; n < 2; n++) begin
      k = 24'($urandom);
      do_preload();
      run_ksa(k, -1, -1);
      check_run("random", k);
    end
  endtask

  task automatic test_back_to_back();
    do_preload();
    run_ksa(24'h123456, -1, -1);
    check_run("b2b_first", 24'h123456);
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_hold: done=%b busy=%b expected 1 0", done, busy);
    end
    run_ksa(24'hA5C3E1, -1, -1);
    checks++;
    if (r_done_c1 !== 0) begin
      errors++;
      $display("FAIL b2b_done_clear: got %0d expected 0", r_done_c1);
    end
    check_run("b2b_second", 24'hA5C3E1);
  endtask

  initial begin
    test_reset();
    test_zero_key();
    test_key_249();
    test_ignored_start();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
